// File: rtl/code_rom_pkg.sv
// Shared state encoding and default sizes for the code ROM load sequencer.
package code_rom_pkg;

    localparam int unsigned CODE_ROM_NUM_BYTES = 32;
    localparam int unsigned CODE_ROM_ADDR_W    = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/code_rom_load_ctr.sv
// Load-session byte counter: ROM write address, remaining-byte terminal compare and,
// when CODE_ROM_CHECKSUM_EN is defined, the running 8-bit modulo sum of accepted bytes.
module code_rom_load_ctr #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_code_rom_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] len_i,
    input  logic              inc_i,
`ifdef CODE_ROM_CHECKSUM_EN
    input  logic [7:0]        data_i,
    output logic [7:0]        sum_o,
`endif
    output logic [ADDR_W-1:0] cnt_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] rem_q, rem_d;

    always_comb begin
        cnt_d = cnt_q;
        rem_d = rem_q;
        if (start_i) begin
            cnt_d = '0;
            rem_d = len_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + ADDR_W'(1);
            rem_d = rem_q - ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_code_rom_n) begin
        if (!reset_code_rom_n) begin
            cnt_q <= '0;
            rem_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rem_q <= rem_d;
        end
    end

    assign cnt_o  = cnt_q;
    // The byte being accepted while one remains is the last of the session.
    assign last_o = (rem_q == ADDR_W'(1));

`ifdef CODE_ROM_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (start_i) begin
            sum_d = 8'h00;
        end else if (inc_i) begin
            sum_d = sum_q + data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_code_rom_n) begin
        if (!reset_code_rom_n) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;
`endif

endmodule

// File: rtl/code_rom_sequencer.sv
// Shares the code ROM ports between the host byte loader and CPU word fetch.
// CODE_ROM_CHECKSUM_EN adds a CHECK phase that validates a trailing checksum byte.
//
// state | meaning
// IDLE  | CPU owns the ROM; word fetches served with one-cycle latency
// LOAD  | host bytes written to consecutive addresses from 0, CPU held
// CHECK | trailing checksum byte accepted (not written), CPU held
// DONE  | one-cycle load_done/load_err report, CPU still held
module code_rom_sequencer
    import code_rom_pkg::*;
#(
    parameter int unsigned NUM_BYTES = CODE_ROM_NUM_BYTES,
    parameter int unsigned ADDR_W    = CODE_ROM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_code_rom_n,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              host_valid,
    input  logic [7:0]        host_data,
    output logic              host_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic              cpu_hold,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [31:0]       fetch_data,
    output logic              fetch_valid,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_wdata,
    input  logic [31:0]       rom_rdata
);

    localparam logic [ADDR_W:0] NUM_BYTES_W = (ADDR_W+1)'(NUM_BYTES);

    state_e            state_q, state_d;
    logic              err_q, err_d;
    logic [31:0]       fetch_data_q, fetch_data_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              ctr_start, ctr_inc, ctr_last;
    logic [ADDR_W-1:0] ctr_cnt;
    logic              fetch_oor;
`ifdef CODE_ROM_CHECKSUM_EN
    logic [7:0]        ctr_sum;
`endif

    code_rom_load_ctr #(
        .ADDR_W (ADDR_W)
    ) u_load_ctr (
        .clk              (clk),
        .reset_code_rom_n (reset_code_rom_n),
        .start_i          (ctr_start),
        .len_i            (load_len),
        .inc_i            (ctr_inc),
`ifdef CODE_ROM_CHECKSUM_EN
        .data_i           (host_data),
        .sum_o            (ctr_sum),
`endif
        .cnt_o            (ctr_cnt),
        .last_o           (ctr_last)
    );

    // Widened by one bit so addresses near the top of the range cannot wrap.
    assign fetch_oor = (({1'b0, fetch_addr} + (ADDR_W+1)'(3)) >= NUM_BYTES_W);

    always_comb begin
        state_d       = state_q;
        err_d         = err_q;
        fetch_data_d  = fetch_data_q;
        fetch_valid_d = 1'b0;
        ctr_start     = 1'b0;
        ctr_inc       = 1'b0;
        host_ready    = 1'b0;
        rom_we        = 1'b0;
        rom_addr      = '0;
        rom_wdata     = 8'h00;

        case (state_q)
            IDLE: begin
                if (load_start) begin
                    ctr_start = 1'b1;
                    err_d     = 1'b0;
                    if (load_len == '0) begin
                        state_d = DONE;
                    end else if ({1'b0, load_len} > NUM_BYTES_W) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end else if (fetch_req) begin
                    rom_addr      = fetch_addr;
                    fetch_valid_d = 1'b1;
                    fetch_data_d  = fetch_oor ? 32'h0 : rom_rdata;
                end
            end
            LOAD: begin
                host_ready = 1'b1;
                if (host_valid) begin
                    rom_we    = 1'b1;
                    rom_addr  = ctr_cnt;
                    rom_wdata = host_data;
                    ctr_inc   = 1'b1;
`ifdef CODE_ROM_CHECKSUM_EN
                    if (ctr_last) state_d = CHECK;
`else
                    if (ctr_last) state_d = DONE;
`endif
                end
            end
            CHECK: begin
`ifdef CODE_ROM_CHECKSUM_EN
                host_ready = 1'b1;
                if (host_valid) begin
                    err_d   = (8'(ctr_sum + host_data) != 8'h00);
                    state_d = DONE;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_code_rom_n) begin
        if (!reset_code_rom_n) begin
            state_q       <= IDLE;
            err_q         <= 1'b0;
            fetch_data_q  <= 32'h0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_q         <= err_d;
            fetch_data_q  <= fetch_data_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    assign load_busy   = (state_q != IDLE);
    assign cpu_hold    = (state_q != IDLE);
    assign load_done   = (state_q == DONE);
    assign load_err    = (state_q == DONE) && err_q;
    assign fetch_data  = fetch_data_q;
    assign fetch_valid = fetch_valid_q;

endmodule

// File: tb/tb_code_rom_sequencer.sv
// Randomized bench for code_rom_sequencer against a session-level reference model
// and a behavioural byte ROM; honours CODE_ROM_CHECKSUM_EN when defined.
module tb_code_rom_sequencer;

    localparam int NB = 32;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset_code_rom_n;
    logic          load_start;
    logic [AW-1:0] load_len;
    logic          host_valid;
    logic [7:0]    host_data;
    logic          host_ready, load_busy, load_done, load_err, cpu_hold;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic [31:0]   fetch_data;
    logic          fetch_valid;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_wdata;
    logic [31:0]   rom_rdata;

    always #5 clk = ~clk;

    code_rom_sequencer #(.NUM_BYTES(NB), .ADDR_W(AW)) dut (
        .clk(clk), .reset_code_rom_n(reset_code_rom_n),
        .load_start(load_start), .load_len(load_len),
        .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
        .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
        .cpu_hold(cpu_hold), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_data(fetch_data), .fetch_valid(fetch_valid),
        .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
        .rom_rdata(rom_rdata)
    );

    // Behavioural ROM written by the DUT, and the contents the bench expects it to hold.
    logic [7:0] mem      [NB];
    logic [7:0] init_mem [NB];
    logic [7:0] ref_mem  [NB];
    logic       rom_init;
    int         rd_a;

    always @(posedge clk) begin
        if (rom_init) begin
            for (int i = 0; i < NB; i++) mem[i] <= init_mem[i];
        end else if (rom_we && int'(rom_addr) < NB) begin
            mem[int'(rom_addr)] <= rom_wdata;
        end
    end

    always_comb begin
        rd_a      = int'(rom_addr);
        rom_rdata = 32'hDEAD_BEEF;
        if (rd_a + 3 < NB) rom_rdata = {mem[rd_a+3], mem[rd_a+2], mem[rd_a+1], mem[rd_a]};
    end

    logic [AW-1:0] wr_addr_q [$];
    logic [7:0]    wr_data_q [$];

    always @(negedge clk) begin
        if (rom_we) begin
            wr_addr_q.push_back(rom_addr);
            wr_data_q.push_back(rom_wdata);
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input int a);
        if (a + 3 >= NB) return 32'h0;
        return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_host_ready"},  host_ready,  0);
        chk({tag, "_load_busy"},   load_busy,   0);
        chk({tag, "_load_done"},   load_done,   0);
        chk({tag, "_load_err"},    load_err,    0);
        chk({tag, "_cpu_hold"},    cpu_hold,    0);
        chk({tag, "_fetch_data"},  fetch_data,  0);
        chk({tag, "_fetch_valid"}, fetch_valid, 0);
        chk({tag, "_rom_we"},      rom_we,      0);
        chk({tag, "_rom_addr"},    rom_addr,    0);
        chk({tag, "_rom_wdata"},   rom_wdata,   0);
    endtask

    // Back-to-back fetches; result checked one cycle after each request.
    task automatic fetch_one(input int a);
        fetch_req  = 1'b1;
        fetch_addr = AW'(a);
        tick();
        chk("fetch_valid", fetch_valid, 1);
        chk("fetch_data", fetch_data, exp_word(a));
    endtask

    task automatic fetch_burst(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) fetch_one(int'($urandom_range(NB, 4095)));
            else fetch_one(int'($urandom_range(0, NB - 1)));
        end
        fetch_req = 1'b0;
        tick();
        chk("fetch_valid_idle", fetch_valid, 0);
    endtask

    // mode 0: host_valid held high, 1: random, 2: pattern 1,0,0,1,0,0...
    task automatic run_session(input int len, input int mode, input bit good_ck);
        logic [7:0] bytes [$];
        logic [7:0] sum, ckb, b;
        int         total, exp_acc, done_cyc, n_wr;
        bit         oversize, exp_err, hv, finished;

        oversize = (len > NB);
        sum      = 8'h00;
        bytes    = {};
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            bytes.push_back(b);
            sum = sum + b;
        end
        ckb = good_ck ? 8'(-sum) : 8'(8'(-sum) + 8'($urandom_range(1, 255)));
`ifdef CODE_ROM_CHECKSUM_EN
        total   = (oversize || len == 0) ? 0 : len + 1;
        exp_err = oversize || (len != 0 && !good_ck);
`else
        total   = oversize ? 0 : len;
        exp_err = oversize;
`endif
        wr_addr_q.delete();
        wr_data_q.delete();

        load_start = 1'b1;
        load_len   = AW'(len);
        fetch_req  = 1'b1;
        fetch_addr = AW'($urandom_range(0, NB - 4));
        tick();

        exp_acc  = 0;
        done_cyc = (total == 0) ? 1 : -1;
        finished = 1'b0;
        for (int k = 1; k <= 400 && !finished; k++) begin
            case (mode)
                0:       hv = 1'b1;
                1:       hv = 1'($urandom_range(0, 1));
                default: hv = ((k % 3) == 1);
            endcase
            host_valid = hv;
            host_data  = (exp_acc < len) ? bytes[exp_acc] : ckb;
            load_start = 1'($urandom_range(0, 1));
            load_len   = AW'($urandom_range(1, NB));
            fetch_req  = 1'($urandom_range(0, 1));
            fetch_addr = AW'($urandom_range(0, NB - 4));
            @(negedge clk);
            chk("host_ready", host_ready, 32'(exp_acc < total));
            chk("load_done", load_done, 32'(k == done_cyc));
            chk("cpu_hold_session", cpu_hold, 1);
            chk("load_busy_session", load_busy, 1);
            chk("fetch_blocked", fetch_valid, 0);
            if (k == done_cyc) begin
                chk("load_err", load_err, 32'(exp_err));
                finished = 1'b1;
            end else if (hv && exp_acc < total) begin
                exp_acc++;
                if (exp_acc == total) done_cyc = k + 1;
            end
            @(posedge clk);
            #1;
        end
        chk("session_finished", 32'(finished), 1);

        host_valid = 1'b0;
        load_start = 1'b0;
        fetch_req  = 1'b0;
        chk("cpu_hold_after", cpu_hold, 0);
        chk("load_busy_after", load_busy, 0);
        chk("load_done_after", load_done, 0);

        n_wr = oversize ? 0 : len;
        chk("write_count", wr_addr_q.size(), n_wr);
        for (int i = 0; i < n_wr && i < wr_addr_q.size(); i++) begin
            chk("write_addr", wr_addr_q[i], i);
            chk("write_data", wr_data_q[i], bytes[i]);
        end
        for (int i = 0; i < n_wr; i++) ref_mem[i] = bytes[i];
    endtask

    initial begin
        logic [7:0] b0, b1;
        reset_code_rom_n = 1'b0;
        load_start = 1'b0; load_len = '0;
        host_valid = 1'b0; host_data = 8'h00;
        fetch_req = 1'b0; fetch_addr = '0;
        rom_init = 1'b1;
        for (int i = 0; i < NB; i++) begin
            init_mem[i] = 8'($urandom);
            ref_mem[i]  = init_mem[i];
        end
        init_mem[0] = 8'h13; init_mem[1] = 8'h00; init_mem[2] = 8'h00; init_mem[3] = 8'h00;
        ref_mem[0]  = 8'h13; ref_mem[1]  = 8'h00; ref_mem[2]  = 8'h00; ref_mem[3]  = 8'h00;
        repeat (2) tick();
        rom_init = 1'b0;
        check_reset_outputs("reset");
        reset_code_rom_n = 1'b1;
        tick();

        fetch_one(0);
        chk("fetch_word0", fetch_data, 32'h0000_0013);
        fetch_one(30);
        fetch_one(28);
        fetch_one(29);
        fetch_one(4095);
        fetch_burst(12);

        run_session(4, 0, 1'b1);
        run_session(40, 1, 1'b1);
        run_session(0, 0, 1'b1);
        run_session(3, 2, 1'b1);
        run_session(2, 0, 1'b1);
        run_session(2, 0, 1'b0);
        run_session(NB, 0, 1'b1);
        run_session(NB + 1, 0, 1'b1);
        fetch_burst(16);

        // Reset in the middle of a 4-byte session after two bytes.
        wr_addr_q.delete();
        wr_data_q.delete();
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        load_start = 1'b1; load_len = AW'(4);
        tick();
        load_start = 1'b0;
        host_valid = 1'b1; host_data = b0;
        tick();
        host_data = b1;
        tick();
        host_data = 8'($urandom);
        #2 reset_code_rom_n = 1'b0;
        #1 check_reset_outputs("midreset");
        tick();
        host_valid = 1'b0;
        chk("midreset_writes", wr_addr_q.size(), 2);
        ref_mem[0] = b0;
        ref_mem[1] = b1;
        reset_code_rom_n = 1'b1;
        tick();
        run_session(4, 0, 1'b1);

        for (int s = 0; s < 12; s++) begin
            run_session(int'($urandom_range(0, NB + 4)), int'($urandom_range(0, 2)),
                        1'($urandom_range(0, 1)));
            if ((s % 4) == 3) fetch_burst(8);
        end
        fetch_burst(20);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "timeout");
    end

endmodule
